alu_uart_interface: RTL and testbench

- Frame-level controller that sits between the UART receiver/transmitter and the ALU toplevel.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them as registered ALU inputs.
- Captures the combinational ALU result and hands it to the UART transmitter through a start/done handshake.
- Replaces the switch/button operand-loading path for host-driven operation.

---
 rtl/alu_uart_interface.sv | 148 ++++++++++++++
 tb/tb_alu_uart_interface.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// Frame controller between the UART and the ALU: collects operand A, operand B
// and opcode bytes, then hands the sign-extended ALU result to the transmitter.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_AB          = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_AB-1:0]   o_alu_a,
  output logic [NB_AB-1:0]   o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_AB-1:0]   i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_rx_drop
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_B,
    ST_GET_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  state_t               state_q, state_d;
  logic [NB_AB-1:0]     alu_a_q, alu_a_d;
  logic [NB_AB-1:0]     alu_b_q, alu_b_d;
  logic [NB_OP-1:0]     alu_op_q, alu_op_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 timeout_q, timeout_d;
  logic                 rx_drop_q, rx_drop_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [NB_AB-1:0] result_s;

  assign result_s = i_alu_result;

  // Handshake: i_rx_done and i_tx_done are single-cycle strobes with no
  // back-pressure; a byte arriving while a result is in flight is dropped
  // and reported on o_rx_drop one cycle later.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    rx_drop_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_rx_done) begin
          alu_a_d = i_rx_data[NB_AB-1:0];
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data[NB_AB-1:0];
          cnt_d   = '0;
          state_d = ST_GET_OP;
        end else if (cnt_q == TERM_COUNT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[NB_OP-1:0];
          cnt_d    = '0;
          state_d  = ST_EXEC;
        end else if (cnt_q == TERM_COUNT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_EXEC: begin
        tx_data_d  = NB_DATA'(result_s);
        tx_start_d = 1'b1;
        rx_drop_d  = i_rx_done;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        rx_drop_d = i_rx_done;
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        rx_drop_d = i_rx_done;
        if (i_tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      rx_drop_q  <= rx_drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_timeout  = timeout_q;
  assign o_rx_drop  = rx_drop_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed frames with literal expectations plus
// randomized byte/ack traffic compared every cycle against a frame-level model.
module tb_alu_uart_interface;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst, rx_done, tx_done;
  logic [7:0] rx_data, alu_res, tx_data, alu_a, alu_b;
  logic [5:0] alu_op;
  logic       tx_start, busy, timeout, rx_drop;

  // second instance with a narrow ALU for sign-extension checks
  logic       q_rst, q_rx_done, q_tx_done;
  logic [7:0] q_rx_data, q_tx_data, q_alu_full;
  logic [3:0] q_a, q_b, q_alu;
  logic [5:0] q_op;
  logic       q_tx_start, q_busy, q_timeout, q_rx_drop;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_a, alu_b, alu_op);
  assign q_alu_full = alu_f({4'h0, q_a}, {4'h0, q_b}, q_op);
  assign q_alu      = q_alu_full[3:0];

  alu_uart_interface #(.NB_DATA(8), .NB_AB(8), .NB_OP(6), .TIMEOUT_CYCLES(TO)) u_dut (
    .clock(clock), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_res),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_timeout(timeout), .o_rx_drop(rx_drop)
  );

  alu_uart_interface #(.NB_DATA(8), .NB_AB(4), .NB_OP(6), .TIMEOUT_CYCLES(TO)) u_dut4 (
    .clock(clock), .i_reset(q_rst), .i_rx_data(q_rx_data), .i_rx_done(q_rx_done),
    .o_alu_a(q_a), .o_alu_b(q_b), .o_alu_op(q_op), .i_alu_result(q_alu),
    .o_tx_data(q_tx_data), .o_tx_start(q_tx_start), .i_tx_done(q_tx_done),
    .o_busy(q_busy), .o_timeout(q_timeout), .o_rx_drop(q_rx_drop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = bytes of the current frame already taken; k = cycles since the
  // opcode byte was taken (0 = collecting); idle = quiet cycles mid-frame.
  logic [7:0] m_a = 0, m_b = 0, m_tx_data = 0;
  logic [5:0] m_op = 0;
  logic       m_tx_start = 0, m_timeout = 0, m_drop = 0;
  int         pos = 0, k = 0, idle = 0;
  logic [7:0] exp_q[$];

  always @(posedge clock) begin
    if (rst) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx_data = 0;
      m_tx_start = 0; m_timeout = 0; m_drop = 0;
      pos = 0; k = 0; idle = 0;
      exp_q.delete();
    end else begin
      m_tx_start = 0; m_timeout = 0; m_drop = 0;
      if (k > 0) begin
        m_drop = rx_done;
        if (k == 1) begin
          m_tx_data = alu_f(m_a, m_b, m_op);
          exp_q.push_back(m_tx_data);
          m_tx_start = 1;
          k = 2;
        end else if (k == 2) begin
          k = 3;
        end else if (tx_done) begin
          k = 0;
        end
      end else if (rx_done) begin
        if (pos == 0) m_a = rx_data;
        else if (pos == 1) m_b = rx_data;
        else m_op = rx_data[5:0];
        pos++;
        idle = 0;
        if (pos == 3) begin
          pos = 0;
          k = 1;
        end
      end else if (pos > 0) begin
        idle++;
        if (idle == TO) begin
          m_timeout = 1;
          pos = 0;
          idle = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("tx_data", 32'(tx_data), 32'(m_tx_data));
    chk("tx_start", 32'(tx_start), 32'(m_tx_start));
    chk("busy", 32'(busy), 32'((k > 0) || (pos > 0)));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("rx_drop", 32'(rx_drop), 32'(m_drop));
    if (tx_start) begin
      if (exp_q.size() == 0) chk("sb_unexpected_start", 32'(1), 32'(0));
      else chk("sb_tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic ack_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] opb, input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    chk({nm, "_a"}, 32'(alu_a), 32'(a));
    chk({nm, "_b"}, 32'(alu_b), 32'(b));
    chk({nm, "_op"}, 32'(alu_op), 32'(opb[5:0]));
    chk({nm, "_start_n1"}, 32'(tx_start), 32'(0));
    tick();
    chk({nm, "_start_n2"}, 32'(tx_start), 32'(1));
    chk({nm, "_data"}, 32'(tx_data), 32'(exp));
    tick();
    chk({nm, "_start_n3"}, 32'(tx_start), 32'(0));
    tick();
    ack_tx();
    chk({nm, "_busy_end"}, 32'(busy), 32'(0));
  endtask

  task automatic q_send(input logic [7:0] b);
    q_rx_data = b;
    q_rx_done = 1'b1;
    tick();
    q_rx_done = 1'b0;
  endtask

  task automatic q_frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input logic [7:0] exp);
    q_send(a);
    q_send(b);
    q_send(opb);
    chk({nm, "_a"}, 32'(q_a), 32'(a[3:0]));
    tick();
    chk({nm, "_start"}, 32'(q_tx_start), 32'(1));
    chk({nm, "_data"}, 32'(q_tx_data), 32'(exp));
    repeat (2) tick();
    q_tx_done = 1'b1;
    tick();
    q_tx_done = 1'b0;
    chk({nm, "_busy_end"}, 32'(q_busy), 32'(0));
  endtask

  logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
  int dens[6] = '{2, 4, 8, 20, 3, 30};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    q_rst = 1'b1; q_rx_done = 1'b0; q_tx_done = 1'b0; q_rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    q_rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_a", 32'(alu_a), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));

    frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);

    // abandoned frame after a lone A byte
    send_byte(8'h07);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_early", 32'(timeout), 32'(0));
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'(1));
    chk("to_busy", 32'(busy), 32'(0));
    chk("to_keep_a", 32'(alu_a), 32'(8'h07));
    frame("or", 8'h01, 8'h02, 8'h25, 8'h03);

    // B arrives exactly on the terminal count
    send_byte(8'h0F);
    repeat (TO - 1) tick();
    send_byte(8'h33);
    chk("term_no_to", 32'(timeout), 32'(0));
    chk("term_b", 32'(alu_b), 32'(8'h33));
    send_byte(8'h26);
    tick();
    chk("term_start", 32'(tx_start), 32'(1));
    chk("term_data", 32'(tx_data), 32'(8'h3C));
    repeat (2) tick();
    ack_tx();

    // drops while a result is outstanding
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h20);
    tick();
    chk("drop_data", 32'(tx_data), 32'(8'h99));
    tick();
    send_byte(8'hAA);
    chk("drop_pulse", 32'(rx_drop), 32'(1));
    chk("drop_keep_a", 32'(alu_a), 32'(8'h44));
    chk("drop_keep_b", 32'(alu_b), 32'(8'h55));
    chk("drop_busy", 32'(busy), 32'(1));
    rx_data = 8'hBB;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    chk("both_drop", 32'(rx_drop), 32'(1));
    chk("both_idle", 32'(busy), 32'(0));
    frame("after_drop", 8'h11, 8'h22, 8'h20, 8'h33);

    // reset while waiting for the opcode
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_a", 32'(alu_a), 32'(0));
    chk("mid_rst_b", 32'(alu_b), 32'(0));
    chk("mid_rst_tx", 32'(tx_data), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_start", 32'(tx_start), 32'(0));
    end
    frame("post_rst", 8'h0C, 8'h0A, 8'h24, 8'h08);

    // narrow ALU: 4-bit result sign-extended onto the byte
    q_frame("n4_sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    q_frame("n4_add", 8'hF3, 8'h02, 8'h20, 8'h05);

    // randomized traffic, including spurious acks and occasional resets
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 500; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        rx_done = ($urandom_range(1, dens[s]) == 1);
        if (pos == 2) rx_data = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
        else rx_data = 8'($urandom);
        tx_done = ($urandom_range(0, 4) == 0);
        tick();
      end
    end
    rst = 1'b0; rx_done = 1'b0; tx_done = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
